// File: rtl/sdfm_fifo_drain_if.sv
// rtl/sdfm_fifo_drain_if.sv - Channel-tagged result stream between the drain engine and its consumer.
interface sdfm_fifo_drain_if;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_chan;

    modport master (output m_valid, output m_data, output m_chan, input m_ready);
    modport slave  (input m_valid, input m_data, input m_chan, output m_ready);
endinterface

// File: rtl/sdfm_fifo_drain.sv
// rtl/sdfm_fifo_drain.sv - Interrupt-driven bus master that drains both sigma-delta FIFOs onto a stream.
// Optional interrupt acknowledge write is compiled in with SDFM_DRAIN_ACK_EN.
module sdfm_fifo_drain #(
    parameter logic [15:0] STAT_ADDR   = 16'h0010,
    parameter logic [15:0] FDATA0_ADDR = 16'h0020,
    parameter logic [15:0] FDATA1_ADDR = 16'h0024,
    parameter logic [15:0] ACK_ADDR    = 16'h0030,
    parameter int          RD_WAIT     = 2,
    parameter int          MAX_BURST   = 8
) (
    input  logic                      EXTCLK,
    input  logic                      EXTRSTn,
    input  logic                      en,
    input  logic                      IRQ,
    output logic                      RD,
    output logic                      WR,
    output logic [15:0]               ADDR,
    inout  wire  [31:0]               DATA,
    sdfm_fifo_drain_if.master         m,
    output logic                      busy,
    output logic [7:0]                spur_cnt
);
    localparam logic [3:0] MAXB     = 4'(MAX_BURST);
    localparam logic [3:0] LAST_CNT = 4'(RD_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE, RD_STAT, RD_DATA, OUT
`ifdef SDFM_DRAIN_ACK_EN
        , ACK
`endif
    } state_t;

    state_t      state_q;
    logic        irq_meta_q, irq_s_q;
    logic        rd_q, m_valid_q, m_chan_q, chan_q, busy_q;
    logic [15:0] addr_q;
    logic [31:0] m_data_q;
    logic [3:0]  cnt_q, lvl0_q, lvl1_q;
    logic [3:0]  lvl0_d, lvl1_d;
    logic [7:0]  spur_q;

    // Status levels clipped so one drain never reads more than MAX_BURST words per channel.
    always_comb begin
        lvl0_d = (DATA[3:0] > MAXB) ? MAXB : DATA[3:0];
        lvl1_d = (DATA[7:4] > MAXB) ? MAXB : DATA[7:4];
    end

`ifdef SDFM_DRAIN_ACK_EN
    logic        wr_q, ch0_drained_q, ch1_drained_q;
    logic [31:0] wdata_q;
    assign WR   = wr_q;
    assign DATA = wr_q ? wdata_q : 32'bz;
`else
    logic unused_ack_addr;
    assign unused_ack_addr = ^ACK_ADDR;
    assign WR   = 1'b0;
    assign DATA = 32'bz;
`endif

    always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
        if (!EXTRSTn) begin
            irq_meta_q <= 1'b0;
            irq_s_q    <= 1'b0;
            state_q    <= IDLE;
            rd_q       <= 1'b0;
            addr_q     <= 16'h0000;
            m_valid_q  <= 1'b0;
            m_data_q   <= 32'h0;
            m_chan_q   <= 1'b0;
            chan_q     <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= 4'd0;
            lvl0_q     <= 4'd0;
            lvl1_q     <= 4'd0;
            spur_q     <= 8'd0;
`ifdef SDFM_DRAIN_ACK_EN
            wr_q          <= 1'b0;
            wdata_q       <= 32'h0;
            ch0_drained_q <= 1'b0;
            ch1_drained_q <= 1'b0;
`endif
        end else begin
            irq_meta_q <= IRQ;
            irq_s_q    <= irq_meta_q;
            case (state_q)
                IDLE: begin
                    if (en && irq_s_q) begin
                        state_q <= RD_STAT;
                        busy_q  <= 1'b1;
                        rd_q    <= 1'b1;
                        addr_q  <= STAT_ADDR;
                        cnt_q   <= 4'd0;
`ifdef SDFM_DRAIN_ACK_EN
                        ch0_drained_q <= 1'b0;
                        ch1_drained_q <= 1'b0;
`endif
                    end
                end
                RD_STAT: begin
                    if (rd_q) begin
                        if (cnt_q == LAST_CNT) begin
                            rd_q   <= 1'b0;
                            lvl0_q <= lvl0_d;
                            lvl1_q <= lvl1_d;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end else if (lvl0_q == 4'd0 && lvl1_q == 4'd0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (spur_q != 8'hFF) spur_q <= spur_q + 8'd1;
                    end else begin
                        state_q <= RD_DATA;
                        chan_q  <= (lvl0_q == 4'd0);
                        rd_q    <= 1'b1;
                        cnt_q   <= 4'd0;
                        addr_q  <= (lvl0_q != 4'd0) ? FDATA0_ADDR : FDATA1_ADDR;
                    end
                end
                RD_DATA: begin
                    if (rd_q) begin
                        if (cnt_q == LAST_CNT) begin
                            rd_q     <= 1'b0;
                            m_data_q <= DATA;
                            m_chan_q <= chan_q;
                            if (chan_q) lvl1_q <= lvl1_q - 4'd1;
                            else        lvl0_q <= lvl0_q - 4'd1;
`ifdef SDFM_DRAIN_ACK_EN
                            if (chan_q) ch1_drained_q <= 1'b1;
                            else        ch0_drained_q <= 1'b1;
`endif
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end else begin
                        m_valid_q <= 1'b1;
                        state_q   <= OUT;
                    end
                end
                OUT: begin
                    if (m.m_ready) begin
                        m_valid_q <= 1'b0;
                        if (chan_q ? (lvl1_q != 4'd0) : (lvl0_q != 4'd0)) begin
                            state_q <= RD_DATA;
                            rd_q    <= 1'b1;
                            cnt_q   <= 4'd0;
                            addr_q  <= chan_q ? FDATA1_ADDR : FDATA0_ADDR;
                        end else if (!chan_q && lvl1_q != 4'd0) begin
                            state_q <= RD_DATA;
                            chan_q  <= 1'b1;
                            rd_q    <= 1'b1;
                            cnt_q   <= 4'd0;
                            addr_q  <= FDATA1_ADDR;
                        end else begin
`ifdef SDFM_DRAIN_ACK_EN
                            state_q <= ACK;
                            wr_q    <= 1'b1;
                            addr_q  <= ACK_ADDR;
                            wdata_q <= {30'b0, ch1_drained_q, ch0_drained_q};
`else
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
`endif
                        end
                    end
                end
`ifdef SDFM_DRAIN_ACK_EN
                ACK: begin
                    if (wr_q) begin
                        wr_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign RD        = rd_q;
    assign ADDR      = addr_q;
    assign m.m_valid = m_valid_q;
    assign m.m_data  = m_data_q;
    assign m.m_chan  = m_chan_q;
    assign busy      = busy_q;
    assign spur_cnt  = spur_q;
endmodule

// File: tb/tb_sdfm_fifo_drain.sv
// tb/tb_sdfm_fifo_drain.sv - Directed self-checking bench for sdfm_fifo_drain with a FIFO bus model.
module tb_sdfm_fifo_drain;
    logic        EXTCLK = 1'b0;
    logic        EXTRSTn = 1'b0;
    logic        en = 1'b0;
    logic        IRQ = 1'b0;
    logic        RD, WR, busy;
    logic [15:0] ADDR;
    tri1  [31:0] DATA;
    logic [7:0]  spur_cnt;
    logic [31:0] stat_word = 32'h0;

    int checks = 0;
    int errors = 0;

    sdfm_fifo_drain_if mif ();

    sdfm_fifo_drain dut (
        .EXTCLK   (EXTCLK),
        .EXTRSTn  (EXTRSTn),
        .en       (en),
        .IRQ      (IRQ),
        .RD       (RD),
        .WR       (WR),
        .ADDR     (ADDR),
        .DATA     (DATA),
        .m        (mif),
        .busy     (busy),
        .spur_cnt (spur_cnt)
    );

    always #5 EXTCLK = ~EXTCLK;

    // Bus slave: FIFO words carry channel tag in the top byte and a 1-based pop index below.
    int n0 = 0;
    int n1 = 0;
    logic [31:0] bus_rdata;
    always_comb begin
        bus_rdata = 32'hDEAD_BEEF;
        if (ADDR == 16'h0010)      bus_rdata = stat_word;
        else if (ADDR == 16'h0020) bus_rdata = 32'hD000_0000 + 32'(n0);
        else if (ADDR == 16'h0024) bus_rdata = 32'hD100_0000 + 32'(n1);
    end
    assign DATA = RD ? bus_rdata : 32'bz;

    logic [15:0] rd_log[$];
    int          run_log[$];
    logic [32:0] out_log[$];
    int          wr_cnt = 0;
    logic [15:0] wr_addr = 16'h0;
    logic [31:0] wr_data = 32'h0;
    int          z_err = 0;
    logic        rd_prev = 1'b0;
    int          rd_run = 0;

    always @(negedge EXTCLK) begin
        if (EXTRSTn) begin
            if (RD && !rd_prev) begin
                rd_log.push_back(ADDR);
                if (ADDR == 16'h0020) n0++;
                if (ADDR == 16'h0024) n1++;
            end
            if (RD) rd_run++;
            else if (rd_prev) begin
                run_log.push_back(rd_run);
                rd_run = 0;
            end
            if (WR) begin
                wr_cnt++;
                wr_addr = ADDR;
                wr_data = DATA;
            end
            if (!WR && !RD && DATA !== 32'hFFFF_FFFF) z_err++;
            if (mif.m_valid && mif.m_ready) out_log.push_back({mif.m_chan, mif.m_data});
        end else begin
            rd_run = 0;
        end
        rd_prev = RD;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge EXTCLK);
        #1;
    endtask

    // which: 0 = busy, 1 = m_valid, 2 = RD
    task automatic wait_sig(input int which, input logic val, input int bound, output bit ok);
        logic s;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            s = (which == 0) ? busy : (which == 1) ? mif.m_valid : RD;
            if (s === val) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        bit ok;
        #1;
        checks++;
        if (RD !== 1'b0 || WR !== 1'b0 || ADDR !== 16'h0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_bus: RD=%b WR=%b ADDR=%h busy=%b required 0 0 0000 0", RD, WR, ADDR, busy);
        end
        checks++;
        if (mif.m_valid !== 1'b0 || mif.m_data !== 32'h0 || mif.m_chan !== 1'b0 || spur_cnt !== 8'h0) begin
            errors++; $display("FAIL reset_stream: valid=%b data=%h chan=%b spur=%0d required all 0", mif.m_valid, mif.m_data, mif.m_chan, spur_cnt);
        end
        checks++;
        if (DATA !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_data_z: DATA=%h required released", DATA); end
        tick(1); EXTRSTn = 1'b1; tick(3);
        stat_word = 32'h32; en = 1'b1; IRQ = 1'b1;
        wait_sig(2, 1'b1, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL reset_wait_rd: RD=%b required 1 within 20 cycles", RD); end
        tick(1); #2;
        EXTRSTn = 1'b0;
        #1;
        checks++;
        if (RD !== 1'b0 || busy !== 1'b0 || mif.m_valid !== 1'b0 || DATA !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL reset_midread: RD=%b busy=%b valid=%b DATA=%h required 0 0 0 released", RD, busy, mif.m_valid, DATA);
        end
        IRQ = 1'b0;
        tick(2); EXTRSTn = 1'b1; tick(3);
    endtask

    task automatic test_basic_drain();
        bit ok;
        int rb = rd_log.size(), ob = out_log.size(), runb = run_log.size(), wb = wr_cnt, b0 = n0, b1 = n1;
        logic [15:0] exp_addr[6] = '{16'h10, 16'h20, 16'h20, 16'h24, 16'h24, 16'h24};
        logic [32:0] exp_out[5];
        exp_out[0] = {1'b0, 32'hD000_0000 + 32'(b0 + 1)};
        exp_out[1] = {1'b0, 32'hD000_0000 + 32'(b0 + 2)};
        exp_out[2] = {1'b1, 32'hD100_0000 + 32'(b1 + 1)};
        exp_out[3] = {1'b1, 32'hD100_0000 + 32'(b1 + 2)};
        exp_out[4] = {1'b1, 32'hD100_0000 + 32'(b1 + 3)};
        stat_word = 32'h0000_0032; mif.m_ready = 1'b1;
        IRQ = 1'b1;
        tick(2);
        checks++;
        if (busy !== 1'b0 || RD !== 1'b0) begin errors++; $display("FAIL irq_latency_early: busy=%b RD=%b required 0 0", busy, RD); end
        tick(1);
        checks++;
        if (RD !== 1'b1 || ADDR !== 16'h0010) begin errors++; $display("FAIL irq_latency_rd: RD=%b ADDR=%h required 1 0010", RD, ADDR); end
        IRQ = 1'b0;
        wait_sig(0, 1'b0, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_done: busy=%b required 0 within 200 cycles", busy); end
        checks++;
        if (rd_log.size() - rb != 6) begin errors++; $display("FAIL basic_nreads: got %0d reads required 6", rd_log.size() - rb); end
        else for (int i = 0; i < 6; i++) begin
            checks++;
            if (rd_log[rb + i] !== exp_addr[i]) begin errors++; $display("FAIL basic_addr%0d: ADDR=%h required %h", i, rd_log[rb + i], exp_addr[i]); end
        end
        checks++;
        if (out_log.size() - ob != 5) begin errors++; $display("FAIL basic_nwords: got %0d words required 5", out_log.size() - ob); end
        else for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_log[ob + i] !== exp_out[i]) begin errors++; $display("FAIL basic_word%0d: chan/data=%h required %h", i, out_log[ob + i], exp_out[i]); end
        end
        for (int i = runb; i < run_log.size(); i++) begin
            checks++;
            if (run_log[i] != 2) begin errors++; $display("FAIL basic_rd_width: RD high %0d cycles required 2", run_log[i]); end
        end
`ifdef SDFM_DRAIN_ACK_EN
        checks++;
        if (wr_cnt - wb != 1 || wr_addr !== 16'h0030 || wr_data !== 32'h3) begin
            errors++; $display("FAIL basic_ack: writes=%0d addr=%h data=%h required 1 0030 00000003", wr_cnt - wb, wr_addr, wr_data);
        end
`else
        checks++;
        if (wr_cnt - wb != 0) begin errors++; $display("FAIL basic_nowrite: writes=%0d required 0", wr_cnt - wb); end
`endif
        tick(3);
    endtask

    task automatic test_spurious();
        int rb = rd_log.size(), wb = wr_cnt;
        stat_word = 32'h0;
        IRQ = 1'b1; tick(1); IRQ = 1'b0;
        tick(2);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL spur_start: busy=%b required 1", busy); end
        tick(2);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL spur_hold: busy=%b required 1", busy); end
        tick(1);
        checks++;
        if (busy !== 1'b0 || spur_cnt !== 8'd1) begin errors++; $display("FAIL spur_end: busy=%b spur=%0d required 0 1", busy, spur_cnt); end
        tick(5);
        checks++;
        if (busy !== 1'b0 || rd_log.size() - rb != 1 || wr_cnt != wb) begin
            errors++; $display("FAIL spur_bus: busy=%b reads=%0d writes=%0d required 0 1 0", busy, rd_log.size() - rb, wr_cnt - wb);
        end
    endtask

    task automatic test_max_burst();
        bit ok;
        int ob = out_log.size(), rb = rd_log.size(), wb = wr_cnt, b0 = n0;
        stat_word = 32'h0000_000C; mif.m_ready = 1'b1;
        IRQ = 1'b1;
        wait_sig(0, 1'b1, 10, ok);
        wait_sig(0, 1'b0, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL burst_done1: busy=%b required 0 within 200 cycles", busy); end
        checks++;
        if (out_log.size() - ob != 8) begin errors++; $display("FAIL burst_words1: got %0d words required 8", out_log.size() - ob); end
`ifdef SDFM_DRAIN_ACK_EN
        checks++;
        if (wr_cnt - wb != 1 || wr_data !== 32'h1) begin errors++; $display("FAIL burst_ack: writes=%0d data=%h required 1 00000001", wr_cnt - wb, wr_data); end
`endif
        tick(1);
        checks++;
        if (busy !== 1'b1 || RD !== 1'b1 || ADDR !== 16'h0010) begin
            errors++; $display("FAIL burst_retrigger: busy=%b RD=%b ADDR=%h required 1 1 0010", busy, RD, ADDR);
        end
        IRQ = 1'b0;
        wait_sig(0, 1'b0, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL burst_done2: busy=%b required 0 within 200 cycles", busy); end
        checks++;
        if (out_log.size() - ob != 16 || rd_log.size() - rb != 18) begin
            errors++; $display("FAIL burst_total: words=%0d reads=%0d required 16 18", out_log.size() - ob, rd_log.size() - rb);
        end else begin
            checks++;
            if (out_log[ob + 8] !== {1'b0, 32'hD000_0000 + 32'(b0 + 9)}) begin
                errors++; $display("FAIL burst_word9: chan/data=%h required %h", out_log[ob + 8], {1'b0, 32'hD000_0000 + 32'(b0 + 9)});
            end
        end
        tick(4);
    endtask

    task automatic test_backpressure();
        bit ok;
        int ob = out_log.size();
        logic [31:0] w1 = 32'hD000_0000 + 32'(n0 + 1);
        logic [31:0] w2 = 32'hD000_0000 + 32'(n0 + 2);
        stat_word = 32'h0000_0002; mif.m_ready = 1'b0;
        IRQ = 1'b1;
        wait_sig(0, 1'b1, 10, ok);
        IRQ = 1'b0;
        wait_sig(1, 1'b1, 50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_valid: m_valid=%b required 1 within 50 cycles", mif.m_valid); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (mif.m_valid !== 1'b1 || mif.m_data !== w1 || mif.m_chan !== 1'b0 || RD !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d: valid=%b data=%h chan=%b RD=%b required 1 %h 0 0", i, mif.m_valid, mif.m_data, mif.m_chan, RD, w1);
            end
            tick(1);
        end
        mif.m_ready = 1'b1;
        tick(1);
        checks++;
        if (RD !== 1'b1 || ADDR !== 16'h0020 || mif.m_valid !== 1'b0) begin
            errors++; $display("FAIL bp_next_read: RD=%b ADDR=%h valid=%b required 1 0020 0", RD, ADDR, mif.m_valid);
        end
        wait_sig(0, 1'b0, 100, ok);
        checks++;
        if (out_log.size() - ob != 2) begin errors++; $display("FAIL bp_words: got %0d words required 2", out_log.size() - ob); end
        else begin
            checks++;
            if (out_log[ob + 1] !== {1'b0, w2}) begin errors++; $display("FAIL bp_word2: chan/data=%h required %h", out_log[ob + 1], {1'b0, w2}); end
        end
        tick(3);
    endtask

    task automatic test_single_ch1();
        bit ok;
        int rb = rd_log.size(), wb = wr_cnt;
        logic [31:0] w = 32'hD100_0000 + 32'(n1 + 1);
        stat_word = 32'h0000_0010; mif.m_ready = 1'b0;
        IRQ = 1'b1;
        wait_sig(0, 1'b1, 10, ok);
        IRQ = 1'b0;
        wait_sig(1, 1'b1, 50, ok);
        checks++;
        if (!ok || mif.m_chan !== 1'b1 || mif.m_data !== w) begin
            errors++; $display("FAIL ch1_word: valid=%b chan=%b data=%h required 1 1 %h", mif.m_valid, mif.m_chan, mif.m_data, w);
        end
        mif.m_ready = 1'b1;
        tick(1);
`ifdef SDFM_DRAIN_ACK_EN
        checks++;
        if (busy !== 1'b1 || WR !== 1'b1 || ADDR !== 16'h0030 || DATA !== 32'h2) begin
            errors++; $display("FAIL ch1_ack: busy=%b WR=%b ADDR=%h DATA=%h required 1 1 0030 00000002", busy, WR, ADDR, DATA);
        end
        tick(1);
        checks++;
        if (WR !== 1'b0 || DATA !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ch1_ack_gap: WR=%b DATA=%h required 0 released", WR, DATA); end
        tick(1);
        checks++;
        if (busy !== 1'b0 || wr_cnt - wb != 1) begin errors++; $display("FAIL ch1_idle: busy=%b writes=%0d required 0 1", busy, wr_cnt - wb); end
`else
        checks++;
        if (busy !== 1'b0 || WR !== 1'b0) begin errors++; $display("FAIL ch1_idle: busy=%b WR=%b required 0 0", busy, WR); end
        checks++;
        if (wr_cnt != 0) begin errors++; $display("FAIL ch1_never_write: total writes=%0d required 0", wr_cnt); end
`endif
        checks++;
        if (rd_log.size() - rb != 2 || rd_log[rb + 1] !== 16'h0024) begin
            errors++; $display("FAIL ch1_reads: reads=%0d required 2 ending at 0024", rd_log.size() - rb);
        end
        tick(3);
        checks++;
        if (z_err != 0) begin errors++; $display("FAIL data_released: %0d idle cycles with DATA driven, required 0", z_err); end
    endtask

    initial begin
        mif.m_ready = 1'b1;
        test_reset();
        test_basic_drain();
        test_spurious();
        test_max_burst();
        test_backpressure();
        test_single_ch1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
